// File: rtl/tx_arbiter_pkg.sv
// Shared constants and state encoding for the TX channel arbiter.
package tx_arbiter_pkg;

  localparam int TX_CMD_BITS = 3;

  // Owner tag stored per outstanding reply.
  localparam logic TX_OWNER_SCHED = 1'b1;
  localparam logic TX_OWNER_PF    = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_S = 2'd1,
    ST_BUSY_P = 2'd2
  } tx_state_t;

endpackage

// File: rtl/tx_reply_tag_fifo.sv
// One-bit-wide FIFO of reply owner tags. Head is the owner of the oldest
// outstanding reply. Push when full and pop when empty are dropped.
module tx_reply_tag_fifo #(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  logic                       i_push_tag,
  input  logic                       i_pop,
  output logic                       o_head,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0] r_mem;
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Storage, pointers (wrap modulo DEPTH) and occupancy count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_push_tag;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/tx_arbiter.sv
// Arbitrates the serial TX channel between the instruction scheduler and
// the PC prefetcher, and steers RX reply completions back to the issuer.
//
// Command handshake: tx_command_valid/tx_command are held while a grant
// exists in IDLE; the command transfers in the cycle where
// tx_command_valid && tx_command_started, and the winner sees *_started
// in that same cycle. tx_command_started without a grant is ignored.
module tx_arbiter
  import tx_arbiter_pkg::*;
#(
  parameter int NSHIFT      = 2,
  parameter int CMD_BITS    = TX_CMD_BITS,
  parameter int MAX_PENDING = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          sched_cmd_valid,
  input  logic [CMD_BITS-1:0]           sched_cmd,
  input  logic                          sched_reply_wanted,
  input  logic                          sched_reserve,
  input  logic [NSHIFT-1:0]             sched_data,
  output logic                          sched_started,
  output logic                          sched_data_next,
  input  logic                          pf_cmd_valid,
  input  logic [CMD_BITS-1:0]           pf_cmd,
  input  logic [NSHIFT-1:0]             pf_data,
  output logic                          pf_started,
  output logic                          pf_data_next,
  output logic                          tx_command_valid,
  output logic [CMD_BITS-1:0]           tx_command,
  input  logic                          tx_command_started,
  output logic [NSHIFT-1:0]             tx_data,
  input  logic                          tx_data_next,
  input  logic                          tx_done,
  input  logic                          rx_done,
  output logic                          rx_owner_sched,
  output logic                          rx_done_sched,
  output logic                          rx_done_pf,
  output logic [$clog2(MAX_PENDING):0]  pending_count,
  output logic                          reply_underflow,
  output logic [1:0]                    dbg_state
);

  tx_state_t r_state;
  tx_state_t w_next_state;
  logic      r_underflow;
  logic      w_grant_s;
  logic      w_grant_p;
  logic      w_push;
  logic      w_push_tag;
  logic      w_head;
  logic      w_full;
  logic      w_empty;

  tx_reply_tag_fifo #(.DEPTH(MAX_PENDING)) u_tag_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_push     (w_push),
    .i_push_tag (w_push_tag),
    .i_pop      (rx_done),
    .o_head     (w_head),
    .o_count    (pending_count),
    .o_full     (w_full),
    .o_empty    (w_empty)
  );

  // Reply steering uses the pre-pop head; nothing is steered when empty.
  assign rx_owner_sched  = w_head && !w_empty;
  assign rx_done_sched   = rx_done && !w_empty && w_head;
  assign rx_done_pf      = rx_done && !w_empty && !w_head;
  assign reply_underflow = r_underflow;
  assign dbg_state       = r_state;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // Sticky underflow flag: rx_done arrived with no reply outstanding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  r_underflow <= 1'b0;
    else if (rx_done && w_empty) r_underflow <= 1'b1;
  end

  // Grant, next-state and channel routing; scheduler has fixed priority.
  always_comb begin
    w_next_state     = r_state;
    w_grant_s        = 1'b0;
    w_grant_p        = 1'b0;
    w_push           = 1'b0;
    w_push_tag       = TX_OWNER_PF;
    tx_command_valid = 1'b0;
    tx_command       = '0;
    tx_data          = '0;
    sched_started    = 1'b0;
    sched_data_next  = 1'b0;
    pf_started       = 1'b0;
    pf_data_next     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_grant_s = sched_cmd_valid && (!sched_reply_wanted || !w_full);
        w_grant_p = !w_grant_s && pf_cmd_valid && !sched_reserve && !w_full;
        if (w_grant_s) begin
          tx_command_valid = 1'b1;
          tx_command       = sched_cmd;
          if (tx_command_started) begin
            sched_started = 1'b1;
            w_next_state  = ST_BUSY_S;
            w_push        = sched_reply_wanted;
            w_push_tag    = TX_OWNER_SCHED;
          end
        end else if (w_grant_p) begin
          tx_command_valid = 1'b1;
          tx_command       = pf_cmd;
          if (tx_command_started) begin
            pf_started   = 1'b1;
            w_next_state = ST_BUSY_P;
            w_push       = 1'b1;
            w_push_tag   = TX_OWNER_PF;
          end
        end
      end
      ST_BUSY_S: begin
        tx_data         = sched_data;
        sched_data_next = tx_data_next;
        if (tx_done) w_next_state = ST_IDLE;
      end
      ST_BUSY_P: begin
        tx_data      = pf_data;
        pf_data_next = tx_data_next;
        if (tx_done) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_tx_arbiter.sv
// Self-checking bench for tx_arbiter: owner tags expected for each reply
// are queued when a reply-wanted command is started and checked when the
// matching rx_done completion is steered.
module tb_tx_arbiter;
  import tx_arbiter_pkg::*;

  localparam int NSHIFT = 2;
  localparam int CB     = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          sched_cmd_valid, sched_reply_wanted, sched_reserve;
  logic [CB-1:0] sched_cmd;
  logic [NSHIFT-1:0] sched_data;
  logic          sched_started, sched_data_next;
  logic          pf_cmd_valid;
  logic [CB-1:0] pf_cmd;
  logic [NSHIFT-1:0] pf_data;
  logic          pf_started, pf_data_next;
  logic          tx_command_valid;
  logic [CB-1:0] tx_command;
  logic          tx_command_started;
  logic [NSHIFT-1:0] tx_data;
  logic          tx_data_next, tx_done, rx_done;
  logic          rx_owner_sched, rx_done_sched, rx_done_pf;
  logic [1:0]    pending_count;
  logic          reply_underflow;
  logic [1:0]    dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [0:0] exp_q[$];

  tx_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .sched_cmd_valid(sched_cmd_valid), .sched_cmd(sched_cmd),
    .sched_reply_wanted(sched_reply_wanted), .sched_reserve(sched_reserve),
    .sched_data(sched_data), .sched_started(sched_started),
    .sched_data_next(sched_data_next),
    .pf_cmd_valid(pf_cmd_valid), .pf_cmd(pf_cmd), .pf_data(pf_data),
    .pf_started(pf_started), .pf_data_next(pf_data_next),
    .tx_command_valid(tx_command_valid), .tx_command(tx_command),
    .tx_command_started(tx_command_started), .tx_data(tx_data),
    .tx_data_next(tx_data_next), .tx_done(tx_done), .rx_done(rx_done),
    .rx_owner_sched(rx_owner_sched), .rx_done_sched(rx_done_sched),
    .rx_done_pf(rx_done_pf), .pending_count(pending_count),
    .reply_underflow(reply_underflow), .dbg_state(dbg_state)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Request a command, wait (bounded) for a grant and start it.
  task automatic start_cmd(input bit is_sched, input logic [CB-1:0] cmd,
                           input logic reply, output bit granted,
                           output logic [CB-1:0] got_cmd,
                           output logic got_started);
    granted = 1'b0;
    got_cmd = '0;
    got_started = 1'b0;
    if (is_sched) begin
      sched_cmd_valid = 1'b1; sched_cmd = cmd; sched_reply_wanted = reply;
    end else begin
      pf_cmd_valid = 1'b1; pf_cmd = cmd;
    end
    for (int i = 0; i < 20 && !granted; i++) begin
      #1;
      if (tx_command_valid === 1'b1) begin
        tx_command_started = 1'b1;
        #1;
        got_cmd     = tx_command;
        got_started = is_sched ? sched_started : pf_started;
        granted     = 1'b1;
        if (!is_sched || reply)
          exp_q.push_back(is_sched ? TX_OWNER_SCHED : TX_OWNER_PF);
      end
      tick();
      tx_command_started = 1'b0;
    end
    sched_cmd_valid = 1'b0;
    sched_reply_wanted = 1'b0;
    pf_cmd_valid = 1'b0;
  endtask

  task automatic finish_txn();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  // Scoreboard: one rx_done, compare steering against the oldest expected owner.
  task automatic scoreboard_rx(input string tag);
    logic [0:0] exp_owner;
    logic exp_s, exp_p;
    rx_done = 1'b1;
    #1;
    if (exp_q.size() == 0) begin
      exp_s = 1'b0; exp_p = 1'b0;
    end else begin
      exp_owner = exp_q.pop_front();
      exp_s = exp_owner[0];
      exp_p = !exp_owner[0];
    end
    n_checks++;
    if ({rx_done_sched, rx_done_pf} !== {exp_s, exp_p}) begin
      n_fail++;
      $display("FAIL %s rx_steer: got sched=%b pf=%b want sched=%b pf=%b",
               tag, rx_done_sched, rx_done_pf, exp_s, exp_p);
    end
    tick();
    rx_done = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    n_checks++;
    if ({tx_command_valid, sched_started, pf_started, rx_done_sched, rx_done_pf} !== 5'b0) begin
      n_fail++; $display("FAIL reset_strobes: got %b want 00000",
        {tx_command_valid, sched_started, pf_started, rx_done_sched, rx_done_pf});
    end
    n_checks++;
    if (pending_count !== 2'd0 || reply_underflow !== 1'b0) begin
      n_fail++; $display("FAIL reset_fifo: got count=%0d uf=%b want 0 0", pending_count, reply_underflow);
    end
    n_checks++;
    if (dbg_state !== ST_IDLE || tx_command !== '0 || tx_data !== '0) begin
      n_fail++; $display("FAIL reset_state: got st=%0d cmd=%0d data=%0d want 0 0 0", dbg_state, tx_command, tx_data);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_prefetch_alone();
    pf_cmd_valid = 1'b1; pf_cmd = 3'd2; pf_data = 2'b01; tx_command_started = 1'b1;
    #1;
    n_checks++;
    if (tx_command_valid !== 1'b1 || tx_command !== 3'd2) begin
      n_fail++; $display("FAIL pf_alone_cmd: got v=%b cmd=%0d want 1 2", tx_command_valid, tx_command);
    end
    n_checks++;
    if (pf_started !== 1'b1 || sched_started !== 1'b0) begin
      n_fail++; $display("FAIL pf_alone_started: got pf=%b s=%b want 1 0", pf_started, sched_started);
    end
    exp_q.push_back(TX_OWNER_PF);
    tick();
    pf_cmd_valid = 1'b0; tx_command_started = 1'b0;
    #1;
    n_checks++;
    if (dbg_state !== ST_BUSY_P || pending_count !== 2'(exp_q.size())) begin
      n_fail++; $display("FAIL pf_alone_busy: got st=%0d cnt=%0d want %0d %0d",
        dbg_state, pending_count, ST_BUSY_P, exp_q.size());
    end
    tx_data_next = 1'b1;
    #1;
    n_checks++;
    if ({pf_data_next, sched_data_next, tx_data} !== {1'b1, 1'b0, 2'b01}) begin
      n_fail++; $display("FAIL pf_alone_data: got pfn=%b sn=%b d=%b want 1 0 01",
        pf_data_next, sched_data_next, tx_data);
    end
    tx_data_next = 1'b0;
    finish_txn();
    n_checks++;
    if (dbg_state !== ST_IDLE) begin
      n_fail++; $display("FAIL pf_alone_idle: got st=%0d want 0", dbg_state);
    end
    scoreboard_rx("pf_alone");
    n_checks++;
    if (pending_count !== 2'd0) begin
      n_fail++; $display("FAIL pf_alone_drain: got cnt=%0d want 0", pending_count);
    end
  endtask

  task automatic test_contention();
    sched_cmd_valid = 1'b1; sched_cmd = 3'd5; sched_reply_wanted = 1'b0;
    pf_cmd_valid = 1'b1; pf_cmd = 3'd3; tx_command_started = 1'b1;
    #1;
    n_checks++;
    if (tx_command !== 3'd5 || sched_started !== 1'b1 || pf_started !== 1'b0) begin
      n_fail++; $display("FAIL contention_grant: got cmd=%0d s=%b p=%b want 5 1 0",
        tx_command, sched_started, pf_started);
    end
    tick();
    sched_cmd_valid = 1'b0;
    sched_data = 2'b10; tx_data_next = 1'b1;
    #1;
    n_checks++;
    if (dbg_state !== ST_BUSY_S || tx_command_valid !== 1'b0 || pf_started !== 1'b0) begin
      n_fail++; $display("FAIL contention_busy: got st=%0d v=%b p=%b want 1 0 0",
        dbg_state, tx_command_valid, pf_started);
    end
    n_checks++;
    if ({sched_data_next, pf_data_next, tx_data} !== {1'b1, 1'b0, 2'b10}) begin
      n_fail++; $display("FAIL contention_data: got sn=%b pn=%b d=%b want 1 0 10",
        sched_data_next, pf_data_next, tx_data);
    end
    tx_data_next = 1'b0; tx_done = 1'b1;
    #1;
    n_checks++;
    if (pf_started !== 1'b0 || tx_command_valid !== 1'b0) begin
      n_fail++; $display("FAIL contention_no_turnaround: got p=%b v=%b want 0 0", pf_started, tx_command_valid);
    end
    tick();
    tx_done = 1'b0;
    #1;
    n_checks++;
    if (pf_started !== 1'b1 || tx_command !== 3'd3) begin
      n_fail++; $display("FAIL contention_pf_next: got p=%b cmd=%0d want 1 3", pf_started, tx_command);
    end
    exp_q.push_back(TX_OWNER_PF);
    tick();
    tx_command_started = 1'b0; pf_cmd_valid = 1'b0;
    finish_txn();
    scoreboard_rx("contention");
  endtask

  task automatic test_reservation();
    int bad = 0;
    sched_reserve = 1'b1; pf_cmd_valid = 1'b1; pf_cmd = 3'd4;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (tx_command_valid !== 1'b0) bad++;
      tick();
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++; $display("FAIL reserve_block: got %0d granted cycles want 0", bad);
    end
    sched_reserve = 1'b0;
    #1;
    n_checks++;
    if (tx_command_valid !== 1'b1 || tx_command !== 3'd4) begin
      n_fail++; $display("FAIL reserve_release: got v=%b cmd=%0d want 1 4", tx_command_valid, tx_command);
    end
    tx_command_started = 1'b1;
    exp_q.push_back(TX_OWNER_PF);
    tick();
    tx_command_started = 1'b0; pf_cmd_valid = 1'b0;
    finish_txn();
    scoreboard_rx("reserve");
  endtask

  task automatic test_fifo_full();
    bit g; logic [CB-1:0] c; logic st;
    for (int i = 0; i < 2; i++) begin
      start_cmd(1'b0, 3'(i + 1), 1'b1, g, c, st);
      finish_txn();
    end
    n_checks++;
    if (pending_count !== 2'd2) begin
      n_fail++; $display("FAIL full_count: got %0d want 2", pending_count);
    end
    pf_cmd_valid = 1'b1; pf_cmd = 3'd3;
    sched_cmd_valid = 1'b1; sched_reply_wanted = 1'b1; sched_cmd = 3'd1;
    #1;
    n_checks++;
    if (tx_command_valid !== 1'b0) begin
      n_fail++; $display("FAIL full_block: got v=%b want 0", tx_command_valid);
    end
    sched_reply_wanted = 1'b0; sched_cmd = 3'd6;
    #1;
    n_checks++;
    if (tx_command_valid !== 1'b1 || tx_command !== 3'd6) begin
      n_fail++; $display("FAIL full_noreply_grant: got v=%b cmd=%0d want 1 6", tx_command_valid, tx_command);
    end
    sched_cmd_valid = 1'b0; pf_cmd_valid = 1'b0;
    start_cmd(1'b1, 3'd6, 1'b0, g, c, st);
    n_checks++;
    if (!g || st !== 1'b1 || pending_count !== 2'd2) begin
      n_fail++; $display("FAIL full_noreply_start: got g=%b st=%b cnt=%0d want 1 1 2", g, st, pending_count);
    end
    finish_txn();
    scoreboard_rx("full_1");
    pf_cmd_valid = 1'b1; pf_cmd = 3'd3;
    #1;
    n_checks++;
    if (tx_command_valid !== 1'b1 || pending_count !== 2'd1) begin
      n_fail++; $display("FAIL full_slot_freed: got v=%b cnt=%0d want 1 1", tx_command_valid, pending_count);
    end
    pf_cmd_valid = 1'b0;
    scoreboard_rx("full_2");
  endtask

  task automatic test_ordering();
    bit g; logic [CB-1:0] c; logic st;
    logic exp_owner;
    start_cmd(1'b1, 3'd7, 1'b1, g, c, st);
    finish_txn();
    start_cmd(1'b0, 3'd2, 1'b1, g, c, st);
    finish_txn();
    n_checks++;
    if (rx_owner_sched !== 1'b1 || pending_count !== 2'd2) begin
      n_fail++; $display("FAIL order_head: got own=%b cnt=%0d want 1 2", rx_owner_sched, pending_count);
    end
    scoreboard_rx("order_1");
    // Next reply-wanted start coincides with a completion.
    sched_cmd_valid = 1'b1; sched_cmd = 3'd7; sched_reply_wanted = 1'b1;
    tx_command_started = 1'b1; rx_done = 1'b1;
    #1;
    exp_owner = exp_q.pop_front();
    n_checks++;
    if ({sched_started, rx_done_sched, rx_done_pf} !== {1'b1, exp_owner, !exp_owner}) begin
      n_fail++; $display("FAIL order_pushpop: got st=%b s=%b p=%b want 1 %b %b",
        sched_started, rx_done_sched, rx_done_pf, exp_owner, !exp_owner);
    end
    exp_q.push_back(TX_OWNER_SCHED);
    tick();
    sched_cmd_valid = 1'b0; sched_reply_wanted = 1'b0;
    tx_command_started = 1'b0; rx_done = 1'b0;
    #1;
    n_checks++;
    if (pending_count !== 2'(exp_q.size())) begin
      n_fail++; $display("FAIL order_count: got %0d want %0d", pending_count, exp_q.size());
    end
    finish_txn();
    scoreboard_rx("order_3");
  endtask

  task automatic test_underflow_reset();
    bit g; logic [CB-1:0] c; logic st;
    scoreboard_rx("underflow");
    repeat (3) tick();
    n_checks++;
    if (reply_underflow !== 1'b1 || pending_count !== 2'd0) begin
      n_fail++; $display("FAIL underflow_sticky: got uf=%b cnt=%0d want 1 0", reply_underflow, pending_count);
    end
    sched_data = 2'b11;
    start_cmd(1'b1, 3'd1, 1'b1, g, c, st);
    tx_data_next = 1'b1;
    #1;
    n_checks++;
    if (dbg_state !== ST_BUSY_S || sched_data_next !== 1'b1 || pending_count !== 2'd1) begin
      n_fail++; $display("FAIL busy_before_reset: got st=%0d sn=%b cnt=%0d want 1 1 1",
        dbg_state, sched_data_next, pending_count);
    end
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    n_checks++;
    if ({sched_data_next, pf_data_next, tx_command_valid, tx_data, pending_count,
         reply_underflow, rx_owner_sched, dbg_state} !== '0) begin
      n_fail++; $display("FAIL reset_mid_busy: got sn=%b v=%b d=%b cnt=%0d uf=%b own=%b st=%0d want all 0",
        sched_data_next, tx_command_valid, tx_data, pending_count, reply_underflow, rx_owner_sched, dbg_state);
    end
    tx_data_next = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    sched_cmd_valid = 1'b0; sched_cmd = '0; sched_reply_wanted = 1'b0;
    sched_reserve = 1'b0; sched_data = '0;
    pf_cmd_valid = 1'b0; pf_cmd = '0; pf_data = NSHIFT'($urandom_range(0, 3));
    tx_command_started = 1'b0; tx_data_next = 1'b0; tx_done = 1'b0; rx_done = 1'b0;
    rst_n = 1'b0;
    test_reset();
    test_prefetch_alone();
    test_contention();
    test_reservation();
    test_fifo_full();
    test_ordering();
    test_underflow_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tx_arbiter.md
Name: tx_arbiter

Overview:
Shares the single serial TX channel between two requesters: the instruction scheduler (data/address transactions) and the PC prefetcher (instruction fetches). It grants one requester at a time, routes command, payload and data-next strobes between the winner and the TX serializer, and honours the scheduler's reservation. A tag FIFO records who owns each outstanding reply, so every RX reply completion is steered back to the requester that issued the command.

Parameters:
NSHIFT, 2, bits per serial transfer cycle (payload/data lane width)
CMD_BITS, 3, width of a TX command (matches TX_CMD_BITS)
MAX_PENDING, 2, max outstanding reply-wanted commands (tag FIFO depth, power of 2, >=2)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
sched_cmd_valid  input  1  scheduler requests a TX command
sched_cmd  input  CMD_BITS  scheduler command
sched_reply_wanted  input  1  scheduler command expects an RX reply
sched_reserve  input  1  scheduler reserves TX; blocks new prefetch grants
sched_data  input  NSHIFT  scheduler payload
sched_started  output  1  scheduler's command accepted this cycle
sched_data_next  output  1  advance scheduler payload
pf_cmd_valid  input  1  prefetcher requests a fetch command
pf_cmd  input  CMD_BITS  prefetcher command (always reply-wanted)
pf_data  input  NSHIFT  prefetcher payload (address)
pf_started  output  1  prefetcher's command accepted this cycle
pf_data_next  output  1  advance prefetcher payload
tx_command_valid  output  1  to TX serializer
tx_command  output  CMD_BITS  to TX serializer
tx_command_started  input  1  serializer accepted command
tx_data  output  NSHIFT  payload to serializer
tx_data_next  input  1  serializer consumed payload chunk
tx_done  input  1  serializer finished transaction
rx_done  input  1  reply fully received
rx_owner_sched  output  1  head reply belongs to scheduler (valid when pending_count!=0)
rx_done_sched  output  1  rx_done steered to scheduler
rx_done_pf  output  1  rx_done steered to prefetcher
pending_count  output  $clog2(MAX_PENDING)+1  outstanding replies
reply_underflow  output  1  sticky error: rx_done with no pending reply

Behaviour:
- States: IDLE, BUSY_S, BUSY_P. Reset -> IDLE; FIFO empty; pending_count=0; reply_underflow=0. Every output reset value is 0; tx_command/tx_data are 0 in IDLE with no request.
- IDLE grant, combinational, same cycle:
  - scheduler wins if sched_cmd_valid and (!sched_reply_wanted or FIFO not full);
  - else prefetcher wins if pf_cmd_valid and !sched_reserve and FIFO not full;
  - else no grant.
  - The scheduler has fixed priority.
- tx_command_valid/tx_command mirror the winner. Both hold low/0 when there is no grant.
- On tx_command_started in IDLE: assert the winner's *_started for that cycle. Next state is BUSY_S or BUSY_P. If reply wanted (sched_reply_wanted, or always for the prefetcher), push the owner tag (1=sched, 0=pf).
- tx_command_started while no grant: ignored, state unchanged.
- BUSY_x:
  - tx_command_valid=0;
  - tx_data = owner's data, else 0;
  - owner's *_data_next = tx_data_next, else 0;
  - the other requester's strobes stay 0.
- tx_done in BUSY_x -> IDLE next cycle. There is no zero-cycle turnaround: a new grant can only occur the cycle after leaving BUSY.
- rx_done:
  - pops the head;
  - rx_done_sched = rx_done & head, rx_done_pf = rx_done & !head (combinational, same cycle).
  - If empty: no pop, both steered outputs 0, reply_underflow set until reset.
- Simultaneous push and pop: both occur; pending_count is unchanged; the pop uses the old head. Pop-when-empty combined with a push: the push succeeds and underflow is flagged.
- Full FIFO: no reply-wanted grant is issued. Non-reply scheduler commands are still granted.
- Pointers are log2(MAX_PENDING) bits and wrap modulo the depth. pending_count is 0..MAX_PENDING.
- rst_n low mid-transaction: immediate return to IDLE, FIFO flushed, strobes low.

Decomposition:
- Owner tag constants (TX_OWNER_SCHED=1, TX_OWNER_PF=0) and state encodings go in common.vh next to TX_CMD_BITS.
- One sub-module: tx_reply_tag_fifo, a 1-bit-wide FIFO of depth MAX_PENDING with push, pop, head, count, full and empty.

Test Plan:
- Prefetch alone: pf_cmd_valid=1, pf_cmd=3'd2, then tx_command_started. Required: tx_command=2 and pf_started=1 that cycle; state BUSY_P; pending_count=1. Then rx_done gives rx_done_pf=1 and pending_count=0.
- Contention: both valid in IDLE. Required: scheduler granted first. pf_started only after tx_done plus one IDLE cycle.
- Reservation: sched_reserve=1, sched_cmd_valid=0, pf_cmd_valid=1. Required: tx_command_valid=0 for 10 cycles, then a grant in the cycle after reserve drops.
- FIFO full at MAX_PENDING=2: two prefetches issued, none received. Required: a third pf request is not granted, while a scheduler command with sched_reply_wanted=0 is granted. rx_done then frees a slot.
- Ordering: issue sched(reply), pf, sched(reply), then 3x rx_done. Required: sched, pf, sched steering. Push and pop in the same cycle leaves the count unchanged.
- Error/reset: rx_done when empty sets reply_underflow=1. Dropping rst_n in BUSY_S makes all outputs 0 and pending_count=0 immediately.
